// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - dual common-data-bus arbiter with round-robin priority
// Grants up to two completed results per cycle and registers them onto CDB1/CDB2.
module cdb_arbiter #(
    parameter int         NUM_REQ  = 4,
    parameter logic [7:0] TAG_NULL = 8'hFF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [8*NUM_REQ-1:0]    req_tag,
    input  logic [64*NUM_REQ-1:0]   req_value,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic                    cdb1_valid,
    output logic [7:0]              cdb1_tag,
    output logic [63:0]             cdb1_value,
    output logic                    cdb2_valid,
    output logic [7:0]              cdb2_tag,
    output logic [63:0]             cdb2_value
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] r_rr_ptr;

    logic [7:0]       w_tag   [NUM_REQ];
    logic [63:0]      w_value [NUM_REQ];
    logic [NUM_REQ-1:0] w_eligible;

    logic             w_found1;
    logic             w_found2;
    logic [PTR_W-1:0] w_idx1;
    logic [PTR_W-1:0] w_idx2;
    logic [PTR_W-1:0] w_probe;

    logic             w_grant_en;
    logic             w_grant1;
    logic             w_grant2;
    logic [PTR_W-1:0] w_next_ptr;

    // A null tag marks a slot that must never reach the bus, even if valid is set.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_tag[i]      = req_tag[8*i +: 8];
            w_value[i]    = req_value[64*i +: 64];
            w_eligible[i] = req_valid[i] && (req_tag[8*i +: 8] != TAG_NULL);
        end
    end

    always_comb begin
        w_found1 = 1'b0;
        w_found2 = 1'b0;
        w_idx1   = '0;
        w_idx2   = '0;
        w_probe  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_probe = r_rr_ptr + PTR_W'(k);
            if (w_eligible[w_probe]) begin
                if (!w_found1) begin
                    w_found1 = 1'b1;
                    w_idx1   = w_probe;
                end else if (!w_found2) begin
                    w_found2 = 1'b1;
                    w_idx2   = w_probe;
                end
            end
        end
    end

    assign w_grant_en = !reset && !flush;
    assign w_grant1   = w_found1 && w_grant_en;
    assign w_grant2   = w_found2 && w_grant_en;

    // Pointer resumes just past the last requester served; wrap is the natural overflow.
    assign w_next_ptr = (w_grant2 ? w_idx2 : w_idx1) + PTR_W'(1);

    always_comb begin
        req_grant = '0;
        if (w_grant1) begin
            req_grant[w_idx1] = 1'b1;
        end
        if (w_grant2) begin
            req_grant[w_idx2] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            cdb1_valid <= 1'b0;
            cdb1_tag   <= TAG_NULL;
            cdb1_value <= 64'h0;
            cdb2_valid <= 1'b0;
            cdb2_tag   <= TAG_NULL;
            cdb2_value <= 64'h0;
        end else begin
            if (w_grant1) begin
                r_rr_ptr <= w_next_ptr;
            end

            if (w_grant1) begin
                cdb1_valid <= 1'b1;
                cdb1_tag   <= w_tag[w_idx1];
                cdb1_value <= w_value[w_idx1];
            end else begin
                cdb1_valid <= 1'b0;
                cdb1_tag   <= TAG_NULL;
                cdb1_value <= 64'h0;
            end

            if (w_grant2) begin
                cdb2_valid <= 1'b1;
                cdb2_tag   <= w_tag[w_idx2];
                cdb2_value <= w_value[w_idx2];
            end else begin
                cdb2_valid <= 1'b0;
                cdb2_tag   <= TAG_NULL;
                cdb2_value <= 64'h0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
// Grants checked per cycle in scenario tasks; CDB broadcasts via a scoreboard queue.
module tb_cdb_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic [3:0]   req_valid = 4'b0;
    logic [31:0]  req_tag = 32'hFFFF_FFFF;
    logic [255:0] req_value = '0;
    logic [3:0]   req_grant;
    logic         cdb1_valid, cdb2_valid;
    logic [7:0]   cdb1_tag, cdb2_tag;
    logic [63:0]  cdb1_value, cdb2_value;

    always #5 clock = ~clock;

    cdb_arbiter #(.NUM_REQ(4), .TAG_NULL(8'hFF)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_value  (req_value),
        .req_grant  (req_grant),
        .cdb1_valid (cdb1_valid),
        .cdb1_tag   (cdb1_tag),
        .cdb1_value (cdb1_value),
        .cdb2_valid (cdb2_valid),
        .cdb2_tag   (cdb2_tag),
        .cdb2_value (cdb2_value)
    );

    typedef struct {
        logic        v1;
        logic [7:0]  t1;
        logic [63:0] d1;
        logic        v2;
        logic [7:0]  t2;
        logic [63:0] d2;
        logic [1:0]  ptr;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [1:0] m_ptr = 2'd0;

    logic [31:0]  tags_1234 = {8'd4, 8'd3, 8'd2, 8'd1};
    logic [255:0] vals_abcd = {64'hD4, 64'hC3, 64'hB2, 64'hA1};

    // Outputs registered at an edge are compared 3 time units later against the
    // entry pushed during the preceding cycle.
    always @(posedge clock) begin
        #3;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            if ({cdb1_valid, cdb1_tag, cdb1_value} !== {mon_e.v1, mon_e.t1, mon_e.d1}) begin
                n_fail++;
                $display("FAIL cdb1 at %0t: got %b/%h/%h expected %b/%h/%h", $time,
                         cdb1_valid, cdb1_tag, cdb1_value, mon_e.v1, mon_e.t1, mon_e.d1);
            end
            n_tests++;
            if ({cdb2_valid, cdb2_tag, cdb2_value} !== {mon_e.v2, mon_e.t2, mon_e.d2}) begin
                n_fail++;
                $display("FAIL cdb2 at %0t: got %b/%h/%h expected %b/%h/%h", $time,
                         cdb2_valid, cdb2_tag, cdb2_value, mon_e.v2, mon_e.t2, mon_e.d2);
            end
            n_tests++;
            if (dut.r_rr_ptr !== mon_e.ptr) begin
                n_fail++;
                $display("FAIL rr_ptr at %0t: got %0d expected %0d", $time, dut.r_rr_ptr, mon_e.ptr);
            end
        end
    end

    // Drives one cycle of stimulus, predicts the grant, and pushes the expected broadcast.
    task automatic cyc(input logic rst, input logic fl, input logic [3:0] v,
                       input logic [31:0] t, input logic [255:0] d, output logic [3:0] g);
        exp_t e;
        int   n;
        int   last;
        @(posedge clock);
        #1;
        reset     = rst;
        flush     = fl;
        req_valid = v;
        req_tag   = t;
        req_value = d;
        @(negedge clock);
        g = 4'b0;
        e.v1 = 1'b0; e.t1 = 8'hFF; e.d1 = 64'h0;
        e.v2 = 1'b0; e.t2 = 8'hFF; e.d2 = 64'h0;
        n = 0;
        last = 0;
        if (rst) begin
            m_ptr = 2'd0;
        end else if (!fl) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (int'(m_ptr) + k) % 4;
                if (v[i] && t[8*i +: 8] != 8'hFF && n < 2) begin
                    g[i] = 1'b1;
                    if (n == 0) begin
                        e.v1 = 1'b1; e.t1 = t[8*i +: 8]; e.d1 = d[64*i +: 64];
                    end else begin
                        e.v2 = 1'b1; e.t2 = t[8*i +: 8]; e.d2 = d[64*i +: 64];
                    end
                    n++;
                    last = i;
                end
            end
            if (n > 0) m_ptr = 2'((last + 1) % 4);
        end
        e.ptr = m_ptr;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [3:0] g;
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 4'b1111, tags_1234, vals_abcd, g);
            n_tests++;
            if (req_grant !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_grant: got %b expected 0000", req_grant);
            end
        end
    endtask

    task automatic test_all_four();
        logic [3:0] g;
        logic [3:0] pat [3];
        pat[0] = 4'b0011; pat[1] = 4'b1100; pat[2] = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 4'b1111, tags_1234, vals_abcd, g);
            n_tests++;
            if (req_grant !== pat[k] || g !== pat[k]) begin
                n_fail++;
                $display("FAIL all_four[%0d]: got %b expected %b", k, req_grant, pat[k]);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] g;
        cyc(1'b0, 1'b0, 4'b1000, {8'h05, 8'hFF, 8'hFF, 8'hFF},
            {64'hDEAD, 64'h0, 64'h0, 64'h0}, g);
        n_tests++;
        if (req_grant !== 4'b1000) begin
            n_fail++;
            $display("FAIL single: got %b expected 1000", req_grant);
        end
    endtask

    task automatic test_null_tag();
        logic [3:0] g;
        cyc(1'b0, 1'b0, 4'b0110, {8'h33, 8'h22, 8'hFF, 8'h11}, vals_abcd, g);
        n_tests++;
        if (req_grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL null_tag: got %b expected 0100", req_grant);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] g;
        cyc(1'b0, 1'b0, 4'b1001, tags_1234, vals_abcd, g);
        n_tests++;
        if (req_grant !== 4'b1001) begin
            n_fail++;
            $display("FAIL wrap_3_0: got %b expected 1001", req_grant);
        end
        cyc(1'b0, 1'b0, 4'b1111, tags_1234, vals_abcd, g);
        n_tests++;
        if (req_grant !== 4'b0110) begin
            n_fail++;
            $display("FAIL wrap_ptr1: got %b expected 0110", req_grant);
        end
    endtask

    task automatic test_flush();
        logic [3:0] g;
        cyc(1'b0, 1'b0, 4'b1111, tags_1234, vals_abcd, g);
        n_tests++;
        if (req_grant !== 4'b1001) begin
            n_fail++;
            $display("FAIL flush_pre: got %b expected 1001", req_grant);
        end
        cyc(1'b0, 1'b1, 4'b1111, tags_1234, vals_abcd, g);
        n_tests++;
        if (req_grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_grant: got %b expected 0000", req_grant);
        end
        cyc(1'b0, 1'b0, 4'b1111, tags_1234, vals_abcd, g);
        n_tests++;
        if (req_grant !== 4'b0110) begin
            n_fail++;
            $display("FAIL flush_post: got %b expected 0110", req_grant);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] g;
        cyc(1'b1, 1'b1, 4'b1111, tags_1234, vals_abcd, g);
        n_tests++;
        if (req_grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_grant: got %b expected 0000", req_grant);
        end
        cyc(1'b0, 1'b0, 4'b1111, tags_1234, vals_abcd, g);
        n_tests++;
        if (req_grant !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_mid_first: got %b expected 0011", req_grant);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   g;
        logic [3:0]   v;
        logic [31:0]  t;
        logic [255:0] d;
        for (int k = 0; k < 40; k++) begin
            v = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                t[8*i +: 8]  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
                d[64*i +: 64] = {$urandom, $urandom};
            end
            cyc(1'b0, ($urandom_range(0, 7) == 0), v, t, d, g);
            n_tests++;
            if (req_grant !== g) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %b expected %b", k, req_grant, g);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_four();
        test_single();
        test_null_tag();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        @(posedge clock);
        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
